// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes if_inst, drives the regfile
// read ports and registers operands/controls into the ID/EX register.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_valid, if_pc, if_inst     fetch handshake and instruction
//   id_ready                     stage can accept an instruction
//   flush                        kill ID/EX contents
//   rd1_addr, rd1_en, op1        regfile read port 1
//   rd2_addr, rd2_en, op2        regfile read port 2
//   ex_ready                     execute accepts ID/EX contents
//   ex_*                         registered ID/EX bundle

package id_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [6:0]  opcode;
    logic        illegal;
  } id_ex_t;

endpackage

module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            id_ready,
  input  logic            flush,
  output logic [4:0]      rd1_addr,
  output logic            rd1_en,
  input  logic [XLEN-1:0] op1,
  output logic [4:0]      rd2_addr,
  output logic            rd2_en,
  input  logic [XLEN-1:0] op2,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_wr_en,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic [6:0]      ex_opcode,
  output logic            ex_illegal
);

  logic [6:0] opc;
  logic [2:0] funct3;
  logic [4:0] rd;

  assign opc    = if_inst[6:0];
  assign funct3 = if_inst[14:12];
  assign rd     = if_inst[11:7];

  logic is_op, is_opimm, is_load, is_store;
  logic is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc, legal;

  assign is_op     = (opc == OPC_OP);
  assign is_opimm  = (opc == OPC_OP_IMM);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_lui    = (opc == OPC_LUI);
  assign is_auipc  = (opc == OPC_AUIPC);

  assign legal = is_op | is_opimm | is_load
               | is_store | is_branch | is_jal
               | is_jalr | is_lui | is_auipc;

  logic [31:0] imm;

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_opimm, is_load, is_jalr:
        imm = {{20{if_inst[31]}},
               if_inst[31:20]};
      is_store:
        imm = {{20{if_inst[31]}},
               if_inst[31:25],
               if_inst[11:7]};
      is_branch:
        imm = {{19{if_inst[31]}},
               if_inst[31], if_inst[7],
               if_inst[30:25],
               if_inst[11:8], 1'b0};
      is_lui, is_auipc:
        imm = {if_inst[31:12], 12'b0};
      is_jal:
        imm = {{11{if_inst[31]}},
               if_inst[31],
               if_inst[19:12],
               if_inst[20],
               if_inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  logic [3:0] alu_op;

  always_comb begin
    alu_op = 4'b0000;
    unique case (1'b1)
      is_op:
        alu_op = {if_inst[30], funct3};
      is_opimm:
        // only the shift-right group uses bit 30 as a selector
        alu_op = {(funct3 == 3'b101) & if_inst[30],
                  funct3};
      default: alu_op = 4'b0000;
    endcase
  end

  logic wr_en;

  assign wr_en = (is_op | is_opimm | is_load
                | is_lui | is_auipc
                | is_jal | is_jalr)
               & (rd != 5'd0);

  assign rd1_addr = if_inst[19:15];
  assign rd2_addr = if_inst[24:20];

  assign rd1_en = if_valid
                & (is_op | is_opimm | is_load
                 | is_store | is_branch | is_jalr);

  assign rd2_en = if_valid
                & (is_op | is_store | is_branch);

  id_ex_t d;
  id_ex_t q;

  always_comb begin
    d             = '0;
    d.valid       = 1'b1;
    d.pc          = if_pc;
    d.rs1_data    = op1;
    d.rs2_data    = op2;
    d.imm         = imm;
    d.rd_addr     = rd;
    d.wr_en       = wr_en;
    d.alu_op      = alu_op;
    d.alu_src_imm = ~(is_op | is_branch);
    d.opcode      = opc;
    d.illegal     = ~legal;
  end

  assign id_ready = ~q.valid | ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      // payload is left as-is; only validity is killed
      q.valid <= 1'b0;
    end else if (id_ready) begin
      if (if_valid) begin
        q <= d;
      end else begin
        q.valid <= 1'b0;
      end
    end
  end

  assign ex_valid       = q.valid;
  assign ex_pc          = q.pc;
  assign ex_rs1_data    = q.rs1_data;
  assign ex_rs2_data    = q.rs2_data;
  assign ex_imm         = q.imm;
  assign ex_rd_addr     = q.rd_addr;
  assign ex_wr_en       = q.wr_en;
  assign ex_alu_op      = q.alu_op;
  assign ex_alu_src_imm = q.alu_src_imm;
  assign ex_opcode      = q.opcode;
  assign ex_illegal     = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand
// sequences for reset/stall/flush, and randomized model comparison.

module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic        flush;
  logic [4:0]  rd1_addr;
  logic        rd1_en;
  logic [31:0] op1;
  logic [4:0]  rd2_addr;
  logic        rd2_en;
  logic [31:0] op2;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd_addr;
  logic        ex_wr_en;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm;
  logic [6:0]  ex_opcode;
  logic        ex_illegal;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .id_ready(id_ready),
    .flush(flush),
    .rd1_addr(rd1_addr), .rd1_en(rd1_en), .op1(op1),
    .rd2_addr(rd2_addr), .rd2_en(rd2_en), .op2(op2),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd_addr(ex_rd_addr), .ex_wr_en(ex_wr_en),
    .ex_alu_op(ex_alu_op),
    .ex_alu_src_imm(ex_alu_src_imm),
    .ex_opcode(ex_opcode), .ex_illegal(ex_illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // decoded meaning of an instruction, from the ISA rules
  typedef struct {
    logic [31:0] imm;
    logic        wr, src, ill, r1, r2;
    logic [3:0]  alu;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t r;
    int   v;
    int   fmt; // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
    bit   op, opi, ld, st, br, jal, jalr, lui, aui;
    op   = i[6:0] == 7'h33;
    opi  = i[6:0] == 7'h13;
    ld   = i[6:0] == 7'h03;
    st   = i[6:0] == 7'h23;
    br   = i[6:0] == 7'h63;
    jal  = i[6:0] == 7'h6F;
    jalr = i[6:0] == 7'h67;
    lui  = i[6:0] == 7'h37;
    aui  = i[6:0] == 7'h17;
    fmt = 0;
    if (opi || ld || jalr) fmt = 1;
    if (st) fmt = 2;
    if (br) fmt = 3;
    if (lui || aui) fmt = 4;
    if (jal) fmt = 5;
    v = 0;
    case (fmt)
      1: v = int'(i[30:20]) - int'(i[31]) * 2048;
      2: v = int'(i[30:25]) * 32 + int'(i[11:7])
           - int'(i[31]) * 2048;
      3: v = int'(i[7]) * 2048 + int'(i[30:25]) * 32
           + int'(i[11:8]) * 2 - int'(i[31]) * 4096;
      4: v = int'(i & 32'hFFFFF000);
      5: v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048
           + int'(i[30:21]) * 2
           - int'(i[31]) * 1048576;
      default: v = 0;
    endcase
    r.imm = 32'(v);
    r.ill = !(op || opi || ld || st || br ||
              jal || jalr || lui || aui);
    r.wr  = (op || opi || ld || lui || aui ||
             jal || jalr) && (i[11:7] != 0);
    r.r1  = op || opi || ld || st || br || jalr;
    r.r2  = op || st || br;
    r.src = !(op || br);
    r.alu = 4'd0;
    if (op) r.alu = {i[30], i[14:12]};
    if (opi)
      r.alu = {(i[14:12] == 3'd5) ? i[30] : 1'b0,
               i[14:12]};
    return r;
  endfunction

  // expected ID/EX register contents
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        wr, src, ill;
    logic [3:0]  alu;
    logic [6:0]  opc;
  } exp_t;

  exp_t m;
  bit   m_init = 0;
  logic [31:0] rf [32];
  dec_t cur;

  task automatic drive(input logic r, fl, v, rdy,
                       input logic [31:0] pc,
                       input logic [31:0] inst);
    @(negedge clk);
    rst = r; flush = fl; if_valid = v;
    ex_ready = rdy; if_pc = pc; if_inst = inst;
    cur = ref_decode(inst);
    rf[0] = 32'd0;
    op1 = (v && cur.r1) ? rf[inst[19:15]] : 32'd0;
    op2 = (v && cur.r2) ? rf[inst[24:20]] : 32'd0;
    #1;
    check("rd1_en", 32'(rd1_en), 32'(v && cur.r1));
    check("rd2_en", 32'(rd2_en), 32'(v && cur.r2));
    check("rd1_addr", 32'(rd1_addr), 32'(inst[19:15]));
    check("rd2_addr", 32'(rd2_addr), 32'(inst[24:20]));
    if (m_init)
      check("id_ready", 32'(id_ready),
            32'(!m.valid || rdy));
  endtask

  task automatic check_ex();
    check("ex_valid", 32'(ex_valid), 32'(m.valid));
    check("ex_pc", ex_pc, m.pc);
    check("ex_rs1_data", ex_rs1_data, m.rs1);
    check("ex_rs2_data", ex_rs2_data, m.rs2);
    check("ex_imm", ex_imm, m.imm);
    check("ex_rd_addr", 32'(ex_rd_addr), 32'(m.rd));
    check("ex_wr_en", 32'(ex_wr_en), 32'(m.wr));
    check("ex_alu_op", 32'(ex_alu_op), 32'(m.alu));
    check("ex_alu_src_imm", 32'(ex_alu_src_imm),
          32'(m.src));
    check("ex_opcode", 32'(ex_opcode), 32'(m.opc));
    check("ex_illegal", 32'(ex_illegal), 32'(m.ill));
  endtask

  // clock edge: advance the model, then compare the register
  task automatic tick();
    bit accept;
    accept = !m_init || !m.valid || ex_ready;
    @(posedge clk);
    if (rst) begin
      m = '{default: '0};
      m_init = 1;
    end else if (flush) begin
      m.valid = 0;
    end else if (accept) begin
      if (if_valid) begin
        m.valid = 1;
        m.pc  = if_pc;
        m.rs1 = op1;
        m.rs2 = op2;
        m.imm = cur.imm;
        m.rd  = if_inst[11:7];
        m.wr  = cur.wr;
        m.src = cur.src;
        m.ill = cur.ill;
        m.alu = cur.alu;
        m.opc = if_inst[6:0];
      end else begin
        m.valid = 0;
      end
    end
    #1;
    if (m_init) check_ex();
  endtask

  task automatic cycle(input logic r, fl, v, rdy,
                       input logic [31:0] pc,
                       input logic [31:0] inst);
    drive(r, fl, v, rdy, pc, inst);
    tick();
  endtask

  typedef struct {
    logic [31:0] inst, rs1d, rs2d, imm;
    logic [4:0]  rd;
    logic        wr, src, ill, r1, r2;
    logic [3:0]  alu;
  } vec_t;

  vec_t tv[$];
  logic [31:0] ri, rpc;

  initial begin
    tv.push_back(vec_t'{32'h00500093, 0, 0, 5,
                 1, 1, 1, 0, 1, 0, 4'h0});
    tv.push_back(vec_t'{32'h0020A423, 32'h100, 32'hFFF,
                 8, 8, 0, 1, 0, 1, 1, 4'h0});
    tv.push_back(vec_t'{32'hFE208EE3, 32'h100, 32'hFFF,
                 32'hFFFFFFFC, 29, 0, 0, 0, 1, 1, 4'h0});
    tv.push_back(vec_t'{32'h123451B7, 0, 0,
                 32'h12345000, 3, 1, 1, 0, 0, 0, 4'h0});
    tv.push_back(vec_t'{32'hFFFFFFFF, 0, 0, 0,
                 31, 0, 1, 1, 0, 0, 4'h0});
    tv.push_back(vec_t'{32'h00100013, 0, 0, 1,
                 0, 0, 1, 0, 1, 0, 4'h0});
    tv.push_back(vec_t'{32'h4030D093, 32'h80, 0,
                 32'h403, 1, 1, 1, 0, 1, 0, 4'hD});
    tv.push_back(vec_t'{32'h002081B3, 32'h11, 32'h22,
                 0, 3, 1, 0, 0, 1, 1, 4'h0});
    tv.push_back(vec_t'{32'h407302B3, 32'h66, 32'h77,
                 0, 5, 1, 0, 0, 1, 1, 4'h8});
    tv.push_back(vec_t'{32'h008000EF, 0, 0, 8,
                 1, 1, 1, 0, 0, 0, 4'h0});
    tv.push_back(vec_t'{32'hC000E093, 32'h5, 0,
                 32'hFFFFFC00, 1, 1, 1, 0, 1, 0, 4'h6});

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1; flush = 0; if_valid = 1; ex_ready = 1;
    if_pc = 0; if_inst = 32'h00500093;
    op1 = 0; op2 = 0;

    // reset held two cycles with a valid instruction present
    cycle(1, 0, 1, 1, 32'h40, 32'h00500093);
    cycle(1, 0, 1, 1, 32'h44, 32'h00500093);
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_ex_imm", ex_imm, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_id_ready", 32'(id_ready), 1);

    // directed table, back-to-back with no bubbles
    for (int k = 0; k < tv.size(); k++) begin
      if (tv[k].r1)
        rf[tv[k].inst[19:15]] = tv[k].rs1d;
      if (tv[k].r2)
        rf[tv[k].inst[24:20]] = tv[k].rs2d;
      drive(0, 0, 1, 1, 32'h1000 + 4 * k, tv[k].inst);
      check("tv_rd1_en", 32'(rd1_en), 32'(tv[k].r1));
      check("tv_rd2_en", 32'(rd2_en), 32'(tv[k].r2));
      tick();
      check("tv_valid", 32'(ex_valid), 1);
      check("tv_pc", ex_pc, 32'h1000 + 4 * k);
      check("tv_rs1", ex_rs1_data, tv[k].rs1d);
      check("tv_rs2", ex_rs2_data, tv[k].rs2d);
      check("tv_imm", ex_imm, tv[k].imm);
      check("tv_rd", 32'(ex_rd_addr), 32'(tv[k].rd));
      check("tv_wr", 32'(ex_wr_en), 32'(tv[k].wr));
      check("tv_src", 32'(ex_alu_src_imm),
            32'(tv[k].src));
      check("tv_ill", 32'(ex_illegal), 32'(tv[k].ill));
      check("tv_alu", 32'(ex_alu_op), 32'(tv[k].alu));
    end

    // bubble when fetch has nothing
    cycle(0, 0, 0, 1, 32'h0, 32'h00500093);
    check("bubble_valid", 32'(ex_valid), 0);

    // stall for 3 cycles behind addi x1,x0,5
    cycle(0, 0, 1, 1, 32'h2000, 32'h00500093);
    for (int s = 0; s < 3; s++) begin
      drive(0, 0, 1, 0, 32'h2004, 32'h123451B7);
      check("stall_ready", 32'(id_ready), 0);
      tick();
      check("stall_imm", ex_imm, 5);
      check("stall_pc", ex_pc, 32'h2000);
    end
    cycle(0, 0, 1, 1, 32'h2004, 32'h123451B7);
    check("unstall_imm", ex_imm, 32'h12345000);
    check("unstall_rd", 32'(ex_rd_addr), 3);

    // flush drops the presented instruction
    cycle(0, 1, 1, 1, 32'h3000, 32'h00100093);
    check("flush_valid", 32'(ex_valid), 0);
    cycle(0, 0, 1, 1, 32'h3004, 32'h00100093);
    check("post_flush_valid", 32'(ex_valid), 1);
    // flush with rst: reset wins
    cycle(1, 1, 1, 1, 32'h3008, 32'h00500093);
    check("rstflush_valid", 32'(ex_valid), 0);
    check("rstflush_pc", ex_pc, 0);
    check("rstflush_rd", 32'(ex_rd_addr), 0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rf[$urandom_range(31)] = $urandom;
      ri = $urandom;
      case ($urandom_range(10))
        0: ri[6:0] = 7'h33;
        1: ri[6:0] = 7'h13;
        2: ri[6:0] = 7'h03;
        3: ri[6:0] = 7'h23;
        4: ri[6:0] = 7'h63;
        5: ri[6:0] = 7'h6F;
        6: ri[6:0] = 7'h67;
        7: ri[6:0] = 7'h37;
        8: ri[6:0] = 7'h17;
        default: ;
      endcase
      rpc = $urandom & 32'hFFFFFFFC;
      cycle($urandom_range(59) == 0,
            $urandom_range(9) == 0,
            $urandom_range(3) != 0,
            $urandom_range(2) != 0,
            rpc, ri);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I core. It sits between the fetch stage and the execute stage, directly in front of the register file. It decodes the fetched instruction and drives the register file's two read ports. It registers the operands, immediate and control fields into the ID/EX pipeline register under a valid/ready handshake, with stall and flush support.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports (one clock domain; reset is synchronous and active-high):
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_pc  in  32  PC of the fetched instruction.
- if_inst  in  32  fetched instruction word.
- id_ready  out  1  stage accepts an instruction this cycle.
- flush  in  1  kill the ID/EX contents (branch redirect or trap).
- rd1_addr  out  5  regfile read port 1 address (inst[19:15]).
- rd1_en  out  1  regfile read port 1 enable.
- op1  in  32  regfile read port 1 data; combinational, 0 when disabled.
- rd2_addr  out  5  regfile read port 2 address (inst[24:20]).
- rd2_en  out  1  regfile read port 2 enable.
- op2  in  32  regfile read port 2 data; combinational, 0 when disabled.
- ex_ready  in  1  execute stage accepts the ID/EX contents.
- ex_valid  out  1  ID/EX register holds a valid instruction.
- ex_pc  out  32  registered PC.
- ex_rs1_data  out  32  registered op1.
- ex_rs2_data  out  32  registered op2.
- ex_imm  out  32  registered sign-extended immediate.
- ex_rd_addr  out  5  destination register (inst[11:7]).
- ex_wr_en  out  1  instruction writes rd.
- ex_alu_op  out  4  {alt bit, funct3}.
- ex_alu_src_imm  out  1  ALU operand B is ex_imm.
- ex_opcode  out  7  registered opcode for EX/MEM control.
- ex_illegal  out  1  opcode is not recognised.

## Operation
- **Supported opcodes:** OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode is illegal.
- **Immediates** are sign-extended from inst[31]:
  - I-type (OP-IMM, LOAD, JALR): inst[31:20].
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - OP and illegal opcodes: immediate = 0.
- **Read enables:**
  - rd1_en = 1 for OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rd2_en = 1 for OP, STORE, BRANCH.
  - Both enables are 0 whenever if_valid = 0.
- **Write enable:** ex_wr_en = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd ≠ 0. It is 0 for illegal opcodes.
- **ALU op:** ex_alu_op = {alt, funct3} for OP and OP-IMM.
  - For OP, alt = inst[30].
  - For OP-IMM, alt = inst[30] only when funct3 = 101, otherwise 0.
  - All other opcodes use 4'b0000 (add).
- **ALU source:** ex_alu_src_imm = 1 for every opcode except OP and BRANCH.
- **Handshake:**
  - id_ready = !ex_valid || ex_ready.
  - An instruction transfers when if_valid && id_ready.
  - On transfer, every ex_* field loads and ex_valid <= 1.
  - If id_ready is high but if_valid is low, ex_valid <= 0.
  - If id_ready is low (stall), every ex_* field holds its value.
- **Flush** has priority over everything else: ex_valid <= 0 on the next edge. id_ready still follows its formula, but any instruction presented during the flush cycle is discarded.
- **Reset** has priority over flush. All ex_* outputs are 0 after reset, and id_ready = 1 in the cycle after reset.
- **Illegal opcodes** still transfer: ex_illegal = 1, ex_wr_en = 0, and both read enables are 0.
- **Read-during-write:** when writeback writes the same register in the same cycle, this block captures whatever the register file returns. Bypassing is not this block's job.

## Timing
- Regfile addresses and enables are combinational from if_inst and if_valid.
- op1 and op2 are captured at the same rising edge as the transfer. ID latency is 1 cycle.
- id_ready is combinational from ex_valid and ex_ready; there is no combinational path from if_valid to id_ready.
- Throughput is one instruction per cycle while ex_ready = 1.
- A stall of N cycles holds the ex_* outputs stable for N cycles.
- When ex_ready = 1 and a new valid instruction arrives on the same edge, the old contents are consumed and replaced with no bubble.

## Test plan
- **Reset:** hold rst = 1 for 2 cycles with if_valid = 1 -> all ex_* = 0 and ex_valid = 0; after release, id_ready = 1.
- **addi x1,x0,5:** if_inst = 0x00500093, regfile op1 = 0 -> rd1_en = 1, rd1_addr = 0, rd2_en = 0. Next cycle: ex_valid = 1, ex_imm = 5, ex_rd_addr = 1, ex_wr_en = 1, ex_alu_op = 0, ex_alu_src_imm = 1.
- **sw then beq back-to-back:** sw x2,8(x1) = 0x0020A423 with op1 = 0x100, op2 = 0xFFF -> ex_imm = 8, ex_rs1_data = 0x100, ex_rs2_data = 0xFFF, ex_wr_en = 0. Then beq x1,x2,-4 = 0xFE208EE3 -> ex_imm = 0xFFFFFFFC, ex_alu_src_imm = 0, with no bubble between them.
- **Stall:** with ex_valid = 1 and ex_ready = 0 for 3 cycles while if_inst = lui x3,0x12345 (0x123451B7) -> id_ready = 0 and ex_* unchanged for all 3 cycles. Then ex_ready = 1 -> next cycle ex_imm = 0x12345000, ex_rd_addr = 3.
- **Flush:** assert flush together with if_valid = 1 -> next cycle ex_valid = 0 and the instruction is dropped. Assert flush and rst together -> reset values.
- **Illegal and corner cases:**
  - if_inst = 0xFFFFFFFF -> ex_illegal = 1, ex_wr_en = 0, rd1_en = rd2_en = 0.
  - addi x0,x0,1 (0x00100013) -> ex_wr_en = 0.
  - srai x1,x1,3 (0x4030D093) -> ex_alu_op = 4'b1101.
